// File: rtl/clint_pkg.sv
// Shared CLINT definitions: register offsets, FSM state type and the byte-merge helper.
package clint_pkg;

  localparam int unsigned CPU_WIDTH = 64;

  localparam logic [63:0] CLINT_MSIP_OFF     = 64'h0000_0000_0000_0000;
  localparam logic [63:0] CLINT_MTIMECMP_OFF = 64'h0000_0000_0000_4000;
  localparam logic [63:0] CLINT_MTIME_OFF    = 64'h0000_0000_0000_BFF8;

  typedef enum logic [0:0] {
    CLINT_IDLE,
    CLINT_RESP
  } clint_state_t;

  function automatic logic [CPU_WIDTH-1:0] merge_wstrb(input logic [CPU_WIDTH-1:0]   old_val,
                                                       input logic [CPU_WIDTH-1:0]   wdata,
                                                       input logic [CPU_WIDTH/8-1:0] wstrb);
    logic [CPU_WIDTH-1:0] res;
    for (int i = 0; i < CPU_WIDTH / 8; i++) begin
      res[i*8 +: 8] = wstrb[i] ? wdata[i*8 +: 8] : old_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// mtime prescaler: counts 0..TICK_DIV-1 and pulses tick on the terminal count.
module clint_prescaler #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam logic [15:0] TermCnt = 16'(TICK_DIV - 1);

  logic [15:0] cnt_q, cnt_d;

  // With TICK_DIV == 1 the terminal count is 0, so tick stays high every cycle.
  assign tick = (cnt_q == TermCnt);

  always_comb begin
    cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: msip/mtimecmp/mtime registers behind a single-outstanding
// valid/ready port, driving the timer and software interrupt levels.
module clint_timer
  import clint_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int unsigned TICK_DIV  = 1,
  parameter int unsigned DATA_W    = CPU_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [63:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                mtime_int,
  output logic                msip_int,
  output logic [DATA_W-1:0]   mtime_o
);

  clint_state_t state_q;

  logic              msip_q, msip_d;
  logic [DATA_W-1:0] mtimecmp_q, mtimecmp_d;
  logic [DATA_W-1:0] mtime_q, mtime_d;
  logic [DATA_W-1:0] msip_merged, cmp_merged, time_merged;
  logic [DATA_W-1:0] rd_val;
  logic [63:0]       offset;
  logic              sel_msip, sel_cmp, sel_time, hit;
  logic              accept, wr_en, tick;
  logic              unused_off;

  clint_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Decode on the doubleword index; byte-within-doubleword bits are ignored.
  assign offset     = req_addr - BASE_ADDR;
  assign unused_off = ^offset[2:0];
  assign sel_msip   = (offset[63:3] == CLINT_MSIP_OFF[63:3]);
  assign sel_cmp    = (offset[63:3] == CLINT_MTIMECMP_OFF[63:3]);
  assign sel_time   = (offset[63:3] == CLINT_MTIME_OFF[63:3]);
  assign hit        = sel_msip | sel_cmp | sel_time;

  assign accept = req_valid && (state_q == CLINT_IDLE);
  assign wr_en  = accept && req_wen;

  always_comb begin
    rd_val = '0;
    if (sel_msip) begin
      rd_val[0] = msip_q;
    end else if (sel_cmp) begin
      rd_val = mtimecmp_q;
    end else if (sel_time) begin
      rd_val = mtime_q;
    end
  end

  assign msip_merged = merge_wstrb({{(DATA_W-1){1'b0}}, msip_q}, req_wdata, req_wstrb);
  assign cmp_merged  = merge_wstrb(mtimecmp_q, req_wdata, req_wstrb);
  assign time_merged = merge_wstrb(mtime_q, req_wdata, req_wstrb);

  always_comb begin
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = tick ? mtime_q + DATA_W'(1) : mtime_q;
    if (wr_en && sel_msip) begin
      msip_d = msip_merged[0];
    end
    if (wr_en && sel_cmp) begin
      mtimecmp_d = cmp_merged;
    end
    // A software write to mtime overrides a coincident tick increment.
    if (wr_en && sel_time) begin
      mtime_d = time_merged;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msip_q     <= 1'b0;
      mtimecmp_q <= '1;
      mtime_q    <= '0;
    end else begin
      msip_q     <= msip_d;
      mtimecmp_q <= mtimecmp_d;
      mtime_q    <= mtime_d;
    end
  end

  // Response is captured at acceptance from pre-update register values and held through RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= CLINT_IDLE;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state_q)
        CLINT_IDLE: begin
          if (req_valid) begin
            state_q   <= CLINT_RESP;
            rsp_err   <= !hit;
            rsp_rdata <= req_wen ? '0 : rd_val;
          end
        end
        CLINT_RESP: begin
          if (rsp_ready) begin
            state_q <= CLINT_IDLE;
          end
        end
      endcase
    end
  end

  assign req_ready = (state_q == CLINT_IDLE);
  assign rsp_valid = (state_q == CLINT_RESP);
  assign mtime_int = (mtime_q >= mtimecmp_q);
  assign msip_int  = msip_q;
  assign mtime_o   = mtime_q;

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Core-local interruptor. Holds the memory-mapped msip, mtimecmp and mtime registers on the core's data-bus side.
- Produces the `mtime_int` level consumed by the CSR/trap unit. Also produces `msip_int` for the software interrupt.
- Exposes a single-outstanding valid/ready request/response port, driven by the LSU address decoder when an access hits the CLINT window.

Parameters:
- BASE_ADDR, 64'h0000_0000_0200_0000, base of the CLINT window.
- TICK_DIV, 1, clk cycles per mtime increment; legal range 1..65535.
- DATA_W, `CPU_WIDTH (64), data and register width.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle.
- req_wen  in  1  1=write, 0=read.
- req_addr  in  64  byte address.
- req_wdata  in  64  write data.
- req_wstrb  in  8  byte enables for writes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  64  read data (0 for writes).
- rsp_err  out  1  access did not hit a mapped register.
- mtime_int  out  1  level: mtime >= mtimecmp.
- msip_int  out  1  level: msip[0].
- mtime_o  out  64  current mtime, for difftest.

Behaviour:
- Register map, offsets from BASE_ADDR:
  - 0x0000 msip: only bit 0 is writable; other bits read 0.
  - 0x4000 mtimecmp.
  - 0xBFF8 mtime.
  - Address bits [2:0] are ignored.
  - Any other offset sets rsp_err=1; writes are dropped and reads return 0.
- Reset, while reset==0, asynchronous:
  - msip=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, mtime=0, prescaler=0.
  - state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - req_ready=1 once reset is released.
- Prescaler:
  - Counts 0..TICK_DIV-1.
  - At terminal count it wraps to 0 and mtime increments by 1 (64-bit, wraps at 2^64-1 to 0).
  - With TICK_DIV=1, mtime increments every cycle.
- FSM, two states:
  - IDLE: req_ready=1. On req_valid, latch the response, apply the write, go to RESP.
  - RESP: req_ready=0, rsp_valid=1. On rsp_ready, go to IDLE.
  - Resulting latency: rsp_valid asserts the cycle after acceptance.
  - Back-to-back requests therefore take a minimum of 2 cycles each.
- Writes:
  - Byte-merged per req_wstrb.
  - Take effect at the acceptance edge.
- Reads:
  - Return the register value before any same-edge update.
  - rsp_rdata/rsp_err hold stable while in RESP.
- Write to mtime on a tick edge: the software write wins and the increment is lost.
  - Prescaler continues counting, not restarted.
- Write to mtimecmp: mtime_int re-evaluates combinationally from the registered values, i.e. it updates the cycle after the write edge.
- mtime_int:
  - Unsigned compare of registered mtime and mtimecmp; no latching.
  - Clears only by raising mtimecmp (or writing mtime below it).
  - Gating by mstatus.MIE/mie.MTIE is the CSR unit's job, not this block's.
- Reset asserted mid-transaction (state RESP): the response is discarded and the block returns to IDLE with the reset values above.
- rsp_ready asserted while in IDLE: ignored.

Decomposition:
- Shared package clint_pkg:
  - Offset constants CLINT_MSIP_OFF, CLINT_MTIMECMP_OFF, CLINT_MTIME_OFF.
  - typedef enum {CLINT_IDLE, CLINT_RESP} clint_state_t.
  - Byte-merge function merge_wstrb(old, wdata, wstrb).
- One sub-module: clint_prescaler, holding the divider counter and tick pulse output.
- Register file and FSM stay in clint_timer.

Test Plan:
- Reset then idle, TICK_DIV=1, 10 cycles -> mtime_o=10, mtime_int=0, msip_int=0; read 0xBFF8 returns 10, including the cycle of acceptance, rsp_err=0.
- Write mtimecmp=20 with wstrb=8'hFF, then wait -> mtime_int rises the cycle mtime_o reaches 20. Then write mtimecmp=100 -> mtime_int=0 the next cycle.
- TICK_DIV=4 -> mtime increments once every 4 clk. Write mtime=5 on a tick edge -> mtime_o=5 afterwards, with no 6 on that cycle.
- Partial write mtimecmp: write all-ones, then wdata=64'h1234 with wstrb=8'h03 -> reads back 64'hFFFF_FFFF_FFFF_1234.
- Write msip=64'hFFFF_FFFF -> msip_int=1 and readback is 1. Access offset 0x0008 -> rsp_err=1, rdata=0, no register changes.
- Hold rsp_ready=0 for 5 cycles after a read -> rsp_valid stays 1, rdata stable, req_ready=0. Pulse reset=0 mid-RESP -> rsp_valid=0 immediately and all reset values restored.
